gauss_window_5x5: RTL and testbench

- Upstream neighbour of the 5x5 Gaussian convolution stage.
- Takes the raster-order 8-bit grey pixel stream from the D8M capture path and buffers four image lines.
- Presents a registered 5x5 neighbourhood, packed as the 200-bit `pixel_data` bus the convolution consumes, with a valid strobe.
- Streaming only: no backpressure, because the camera cannot stall.

---
 rtl/gauss_pkg.sv | 13 +
 rtl/gauss_line_buf.sv | 31 +++
 rtl/gauss_window_5x5.sv | 121 ++++++++++++
 tb/tb_gauss_window_5x5.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared constants and tap packing for the 5x5 Gaussian window and convolution stages.
package gauss_pkg;

  localparam int KSIZE     = 5;
  localparam int NTAPS     = KSIZE * KSIZE;
  localparam int PIX_W_DEF = 8;

  // Tap k of the packed window bus lives at [k*PIX_W +: PIX_W].
  function automatic int tap_idx(input int r, input int c);
    return r * KSIZE + c;
  endfunction

endpackage

// File: rtl/gauss_line_buf.sv
// One image-line delay: simple dual-port RAM with a registered, read-before-write read port.
module gauss_line_buf
  import gauss_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int W     = PIX_W_DEF,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/gauss_window_5x5.sv
// 5x5 neighbourhood generator for the Gaussian stage: four chained line buffers plus a shift window.
// Optional macro GAUSS_WIN_POS_EN adds out_col/out_row (centre-pixel coordinates of each window).
module gauss_window_5x5
  import gauss_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = PIX_W_DEF,
  localparam int CW        = $clog2(IMG_WIDTH),
  localparam int RW        = $clog2(IMG_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [PIX_W-1:0]       in_pixel,
  output logic                   out_valid,
`ifdef GAUSS_WIN_POS_EN
  output logic [CW-1:0]          out_col,
  output logic [RW-1:0]          out_row,
`endif
  output logic [NTAPS*PIX_W-1:0] pixel_data
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_EDGE = RW'(KSIZE - 1);

  logic [CW-1:0]    col, col_q, cur_col;
  logic [RW-1:0]    row, cur_row;
  logic [PIX_W-1:0] pix_q;
  logic [PIX_W-1:0] buf_rd [KSIZE-1];
  logic [PIX_W-1:0] buf_wd [KSIZE-1];
  logic [PIX_W-1:0] col4   [KSIZE];
  logic [PIX_W-1:0] win    [KSIZE][KSIZE-1];

  // A start-of-frame pixel is placed at (0,0) regardless of the running counters.
  always_comb begin
    cur_col = in_sof ? '0 : col;
    cur_row = in_sof ? '0 : row;
  end

  // Newest column of the window: buffer read data and the pixel captured on the same edge.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) col4[r] = '0;
    col4[KSIZE-1] = pix_q;
    for (int r = 0; r < KSIZE - 1; r++) col4[r] = buf_rd[KSIZE-2-r];
  end

  // Each buffer is written one accept late, at the address the chain read last time,
  // with the value the previous stage produced for that address.
  always_comb begin
    buf_wd[0] = pix_q;
    for (int n = 1; n < KSIZE - 1; n++) buf_wd[n] = buf_rd[n-1];
  end

  for (genvar n = 0; n < KSIZE - 1; n++) begin : g_lb
    gauss_line_buf #(
      .DEPTH (IMG_WIDTH),
      .W     (PIX_W)
    ) u_line_buf (
      .clk   (clk),
      .rst   (rst),
      .re    (in_valid),
      .raddr (cur_col),
      .we    (in_valid),
      .waddr (col_q),
      .wdata (buf_wd[n]),
      .rdata (buf_rd[n])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      col_q     <= '0;
      pix_q     <= '0;
      out_valid <= 1'b0;
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE - 1; c++)
          win[r][c] <= '0;
`ifdef GAUSS_WIN_POS_EN
      out_col   <= '0;
      out_row   <= '0;
`endif
    end else begin
      out_valid <= in_valid && (cur_row >= ROW_EDGE) && (cur_col >= COL_EDGE);
      if (in_valid) begin
        pix_q <= in_pixel;
        col_q <= cur_col;
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE - 2; c++) win[r][c] <= win[r][c+1];
          win[r][KSIZE-2] <= col4[r];
        end
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
`ifdef GAUSS_WIN_POS_EN
        out_col <= cur_col - CW'(2);
        out_row <= cur_row - RW'(2);
`endif
      end
    end
  end

  always_comb begin
    pixel_data = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++)
        pixel_data[tap_idx(r, c)*PIX_W +: PIX_W] = win[r][c];
      pixel_data[tap_idx(r, KSIZE-1)*PIX_W +: PIX_W] = col4[r];
    end
  end

endmodule

// File: tb/tb_gauss_window_5x5.sv
// Self-checking bench for gauss_window_5x5 on an 8x6 image against an image-array reference model.
module tb_gauss_window_5x5;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 25 * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [7:0]    in_pixel;
  logic          out_valid;
  logic [DW-1:0] pixel_data;
`ifdef GAUSS_WIN_POS_EN
  logic [2:0]    out_col;
  logic [2:0]    out_row;
`endif

  int checks   = 0;
  int failures = 0;

  gauss_window_5x5 #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
`ifdef GAUSS_WIN_POS_EN
    .out_col    (out_col),
    .out_row    (out_row),
`endif
    .pixel_data (pixel_data)
  );

  always #5 clk = ~clk;

  // Reference model: the image as written so far, and the linear raster position.
  logic [7:0]    img [H][W];
  int            pos;
  logic          m_valid;
  logic [DW-1:0] m_data;
  bit            m_known;
  logic [2:0]    m_col;
  logic [2:0]    m_row;
  int            m_r, m_c;

  function automatic logic [7:0] ramp(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  task automatic reset_dut();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    pos = 0; m_valid = 1'b0; m_data = '0; m_known = 1'b1; m_col = '0; m_row = '0;
  endtask

  task automatic send(input logic v, input logic s, input logic [7:0] pix);
    in_valid = v; in_sof = s; in_pixel = pix;
    m_valid = 1'b0;
    if (v) begin
      if (s) pos = 0;
      m_r = pos / W;
      m_c = pos % W;
      img[m_r][m_c] = pix;
      m_valid = (m_r >= 4) && (m_c >= 4);
      if (m_valid) begin
        for (int rr = 0; rr < 5; rr++)
          for (int cc = 0; cc < 5; cc++)
            m_data[(rr*5+cc)*8 +: 8] = img[m_r-4+rr][m_c-4+cc];
        m_known = 1'b1;
        m_col = 3'(m_c - 2);
        m_row = 3'(m_r - 2);
      end else begin
        m_known = 1'b0;
      end
      pos = (pos + 1) % (W * H);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0b want=0", out_valid);
    end
    checks++;
    if (pixel_data !== '0) begin
      failures++; $display("FAIL reset_data got=%h want=0", pixel_data);
    end
  endtask

  task automatic test_ramp_frame();
    int nval = 0;
    logic [DW-1:0] last_win = '0;
    for (int i = 0; i < W * H; i++) begin
      send(1'b1, i == 0, ramp(i / W, i % W));
      checks++;
      if (out_valid !== m_valid) begin
        failures++; $display("FAIL ramp_valid i=%0d got=%0b want=%0b", i, out_valid, m_valid);
      end
      if (m_known) begin
        checks++;
        if (pixel_data !== m_data) begin
          failures++; $display("FAIL ramp_data i=%0d got=%h want=%h", i, pixel_data, m_data);
        end
      end
      if (out_valid === 1'b1) begin
        if (nval == 0) begin
          checks += 3;
          if (pixel_data[0 +: 8] !== 8'h00 || pixel_data[12*8 +: 8] !== 8'h22 ||
              pixel_data[24*8 +: 8] !== 8'h44) begin
            failures++;
            $display("FAIL ramp_first_taps got=%h/%h/%h want=00/22/44",
                     pixel_data[0 +: 8], pixel_data[12*8 +: 8], pixel_data[24*8 +: 8]);
          end
`ifdef GAUSS_WIN_POS_EN
          checks++;
          if (out_col !== 3'd2 || out_row !== 3'd2) begin
            failures++; $display("FAIL ramp_first_pos got=%0d,%0d want=2,2", out_col, out_row);
          end
`endif
        end
        if ((i % W) < 4) begin
          failures++; $display("FAIL ramp_straddle i=%0d got=1 want=0", i);
        end
        nval++;
        last_win = pixel_data;
      end
    end
    checks++;
    if (nval != 8) begin
      failures++; $display("FAIL ramp_count got=%0d want=8", nval);
    end
    checks++;
    if (last_win[24*8 +: 8] !== 8'h57 || last_win[0 +: 8] !== 8'h13) begin
      failures++;
      $display("FAIL ramp_last_taps got=%h/%h want=57/13", last_win[24*8 +: 8], last_win[0 +: 8]);
    end
`ifdef GAUSS_WIN_POS_EN
    checks++;
    if (out_col !== 3'd5 || out_row !== 3'd3) begin
      failures++; $display("FAIL ramp_last_pos got=%0d,%0d want=5,3", out_col, out_row);
    end
`endif
  endtask

  task automatic test_gaps();
    int nval = 0;
    for (int i = 0; i < W * H; i++) begin
      for (int g = 0; g < 4; g++) begin
        if (g == 0) send(1'b1, i == 0, ramp(i / W, i % W));
        else        send(1'b0, 1'b0, 8'hA5);
        checks++;
        if (out_valid !== m_valid) begin
          failures++; $display("FAIL gaps_valid i=%0d g=%0d got=%0b want=%0b", i, g, out_valid, m_valid);
        end
        if (m_known) begin
          checks++;
          if (pixel_data !== m_data) begin
            failures++; $display("FAIL gaps_data i=%0d g=%0d got=%h want=%h", i, g, pixel_data, m_data);
          end
        end
        if (out_valid === 1'b1) nval++;
      end
    end
    checks++;
    if (nval != 8) begin
      failures++; $display("FAIL gaps_count got=%0d want=8", nval);
    end
  endtask

  task automatic test_resync();
    int nval = 0;
    int first = -1;
    for (int i = 0; i < 20; i++) send(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < W * H; i++) begin
      send(1'b1, i == 0, ramp(i / W, i % W));
      checks++;
      if (out_valid !== m_valid) begin
        failures++; $display("FAIL resync_valid i=%0d got=%0b want=%0b", i, out_valid, m_valid);
      end
      if (m_known) begin
        checks++;
        if (pixel_data !== m_data) begin
          failures++; $display("FAIL resync_data i=%0d got=%h want=%h", i, pixel_data, m_data);
        end
      end
      if (out_valid === 1'b1) begin
        if (first < 0) first = i;
        nval++;
      end
    end
    checks++;
    if (first != 4 * W + 4 || nval != 8) begin
      failures++; $display("FAIL resync_first got=%0d/%0d want=%0d/8", first, nval, 4 * W + 4);
    end
  endtask

  task automatic test_mid_reset();
    int nval = 0;
    for (int i = 0; i <= 4 * W + 5; i++) send(1'b1, i == 0, ramp(i / W, i % W));
    reset_dut();
    checks++;
    if (out_valid !== 1'b0 || pixel_data !== '0) begin
      failures++; $display("FAIL midrst_clear got=%0b/%h want=0/0", out_valid, pixel_data);
    end
    for (int i = 0; i < W * H; i++) begin
      send(1'b1, 1'b0, 8'(8'hC0 ^ ramp(i / W, i % W)));
      checks++;
      if (out_valid !== m_valid) begin
        failures++; $display("FAIL midrst_valid i=%0d got=%0b want=%0b", i, out_valid, m_valid);
      end
      if (m_known) begin
        checks++;
        if (pixel_data !== m_data) begin
          failures++; $display("FAIL midrst_data i=%0d got=%h want=%h", i, pixel_data, m_data);
        end
      end
      if (out_valid === 1'b1) nval++;
    end
    checks++;
    if (nval != 8) begin
      failures++; $display("FAIL midrst_count got=%0d want=8", nval);
    end
  endtask

  task automatic test_random();
    int acc = 0;
    for (int cyc = 0; cyc < 2000 && acc < 2 * W * H; cyc++) begin
      logic v;
      v = ($urandom_range(0, 9) < 7);
      send(v, v && acc == 0, 8'($urandom));
      if (v) acc++;
      checks++;
      if (out_valid !== m_valid) begin
        failures++; $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", cyc, out_valid, m_valid);
      end
      if (m_known) begin
        checks++;
        if (pixel_data !== m_data) begin
          failures++; $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, pixel_data, m_data);
        end
      end
`ifdef GAUSS_WIN_POS_EN
      if (m_valid) begin
        checks++;
        if (out_col !== m_col || out_row !== m_row) begin
          failures++;
          $display("FAIL rand_pos cyc=%0d got=%0d,%0d want=%0d,%0d", cyc, out_col, out_row, m_col, m_row);
        end
      end
`endif
    end
    checks++;
    if (acc < 2 * W * H) begin
      failures++; $display("FAIL rand_budget got=%0d want=%0d", acc, 2 * W * H);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_ramp_frame();
    test_gaps();
    test_resync();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
